// File: rtl/ahb_req2mst.sv
// Converts one command at a time into a single AHB-Lite transfer and reports the outcome.
// Misaligned or oversized commands are answered locally with an error.
module ahb_req2mst #(
  parameter logic [31:0] P_ADDR_MASK = 32'hFFFFFFFF,
  parameter logic [31:0] P_ADDR_BASE = 32'h00000000,
  parameter logic [3:0]  P_HPROT     = 4'b0011
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        cmd_req,
  input  logic [31:0] cmd_addr,
  input  logic        cmd_write,
  input  logic [2:0]  cmd_size,
  input  logic [31:0] cmd_wdata,
  output logic        cmd_busy,
  output logic        cmd_ack,
  output logic [31:0] cmd_rdata,
  output logic        cmd_err,
  output logic [31:0] ahb_mst_haddr,
  output logic [1:0]  ahb_mst_htrans,
  output logic        ahb_mst_hwrite,
  output logic [2:0]  ahb_mst_hsize,
  output logic [2:0]  ahb_mst_hburst,
  output logic [3:0]  ahb_mst_hprot,
  output logic [31:0] ahb_mst_hwdata,
  output logic        ahb_mst_hlock,
  input  logic [31:0] ahb_mst_hrdata,
  input  logic        ahb_mst_hready,
  input  logic [1:0]  ahb_mst_hresp
);

  // state | meaning
  // IDLE  | waiting for cmd_req; illegal commands are answered from here
  // ADDR  | NONSEQ address phase, held until hready
  // DATA  | data phase, held until hready; completion reported next cycle
  typedef enum logic [1:0] {IDLE, ADDR, DATA} state_t;

  localparam logic [1:0] HTRANS_IDLE   = 2'b00;
  localparam logic [1:0] HTRANS_NONSEQ = 2'b10;

  state_t      state;
  logic [31:0] wdata_q;
  logic        legal;

  always_comb begin
    legal = 1'b0;
    case (cmd_size)
      3'd0:    legal = 1'b1;
      3'd1:    legal = ~cmd_addr[0];
      3'd2:    legal = (cmd_addr[1:0] == 2'b00);
      default: legal = 1'b0;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state          <= IDLE;
      wdata_q        <= '0;
      ahb_mst_htrans <= HTRANS_IDLE;
      ahb_mst_haddr  <= '0;
      ahb_mst_hwrite <= 1'b0;
      ahb_mst_hsize  <= '0;
      ahb_mst_hwdata <= '0;
      cmd_ack        <= 1'b0;
      cmd_err        <= 1'b0;
      cmd_rdata      <= '0;
    end else begin
      cmd_ack <= 1'b0;
      case (state)
        IDLE: begin
          if (cmd_req) begin
            if (legal) begin
              state          <= ADDR;
              ahb_mst_htrans <= HTRANS_NONSEQ;
              ahb_mst_haddr  <= (cmd_addr & P_ADDR_MASK) | P_ADDR_BASE;
              ahb_mst_hwrite <= cmd_write;
              ahb_mst_hsize  <= cmd_size;
              wdata_q        <= cmd_wdata;
            end else begin
              cmd_ack   <= 1'b1;
              cmd_err   <= 1'b1;
              cmd_rdata <= '0;
            end
          end
        end
        ADDR: begin
          if (ahb_mst_hready) begin
            state          <= DATA;
            ahb_mst_htrans <= HTRANS_IDLE;
            ahb_mst_hwdata <= ahb_mst_hwrite ? wdata_q : 32'd0;
          end
        end
        DATA: begin
          // The first cycle of an ERROR response has hready low, so it is simply waited out.
          if (ahb_mst_hready) begin
            state          <= IDLE;
            ahb_mst_hwdata <= '0;
            cmd_ack        <= 1'b1;
            cmd_err        <= (ahb_mst_hresp != 2'b00);
            cmd_rdata      <= ahb_mst_hwrite ? 32'd0 : ahb_mst_hrdata;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  assign cmd_busy       = (state != IDLE);
  assign ahb_mst_hburst = 3'b000;
  assign ahb_mst_hprot  = P_HPROT;
  assign ahb_mst_hlock  = 1'b0;

endmodule

// File: doc/ahb_req2mst.md
AHB_REQ2MST -- requirements
Module: ahb_req2mst

Interface
REQ-001 SHALL have parameter P_ADDR_MASK, default 32'hFFFFFFFF: AND mask applied to the captured command address.
REQ-002 SHALL have parameter P_ADDR_BASE, default 32'h00000000: OR base applied after masking.
REQ-003 SHALL have parameter P_HPROT, default 4'b0011: constant driven on ahb_mst_hprot.
REQ-004 SHALL have ports:
- clk  in  1  single clock; all state on its rising edge.
- rst  in  1  reset, asynchronous, active-high.
- cmd_req  in  1  command request.
- cmd_addr  in  32  byte address.
- cmd_write  in  1  1=write, 0=read.
- cmd_size  in  3  HSIZE encoding, 0..2 legal.
- cmd_wdata  in  32  write data.
- cmd_busy  out  1  command in progress.
- cmd_ack  out  1  one-cycle completion pulse.
- cmd_rdata  out  32  read data, valid with cmd_ack.
- cmd_err  out  1  error flag, valid with cmd_ack.
- ahb_mst_haddr  out  32  AHB address.
- ahb_mst_htrans  out  2  AHB transfer type.
- ahb_mst_hwrite  out  1  AHB direction.
- ahb_mst_hsize  out  3  AHB size.
- ahb_mst_hburst  out  3  AHB burst, constant 3'b000 (SINGLE).
- ahb_mst_hprot  out  4  AHB protection, constant P_HPROT.
- ahb_mst_hwdata  out  32  AHB write data.
- ahb_mst_hlock  out  1  AHB lock, constant 0.
- ahb_mst_hrdata  in  32  AHB read data.
- ahb_mst_hready  in  1  AHB transfer-done.
- ahb_mst_hresp  in  2  AHB response; 2'b00 is OKAY.

Function
REQ-005 SHALL implement an FSM with states IDLE, ADDR and DATA; cmd_busy SHALL be 1 exactly when the state is not IDLE.
REQ-006 SHALL accept a command on a rising edge where cmd_req=1 and the state is IDLE, capturing all cmd_* inputs at that edge; cmd_req SHALL be ignored in ADDR and DATA.
REQ-007 SHALL treat an accepted command as illegal when cmd_size>2, or when cmd_size=1 and addr[0]!=0, or when cmd_size=2 and addr[1:0]!=0.
REQ-008 On an illegal command, the FSM SHALL stay in IDLE, issue no bus transfer, and pulse cmd_ack=1 with cmd_err=1 and cmd_rdata=0 in the next cycle.
REQ-009 On a legal command, IDLE SHALL go to ADDR.
REQ-010 In ADDR, outputs SHALL be: htrans=2'b10 (NONSEQ), haddr=(addr & P_ADDR_MASK) | P_ADDR_BASE, plus the captured hwrite and hsize.
REQ-011 ADDR SHALL hold all its outputs unchanged while ahb_mst_hready=0, and SHALL go to DATA on the edge where ahb_mst_hready=1.
REQ-012 In DATA and IDLE, htrans SHALL be 2'b00; haddr, hwrite and hsize SHALL hold their last values.
REQ-013 In DATA, hwdata SHALL equal the captured wdata for writes; in all other cases and states, hwdata SHALL be 0.
REQ-014 DATA SHALL wait while ahb_mst_hready=0, including the first cycle of a two-cycle ERROR response.
REQ-015 On the DATA edge with ahb_mst_hready=1, the FSM SHALL go to IDLE and, in the next cycle, drive cmd_ack=1, cmd_err=(hresp!=2'b00), and cmd_rdata=hrdata for reads or 0 for writes.
REQ-016 cmd_ack SHALL be high for exactly one cycle per accepted command; cmd_rdata and cmd_err SHALL hold until the next cmd_ack.
REQ-017 A cmd_req present in the same cycle as cmd_ack SHALL be accepted (back-to-back operation); the minimum period is 3 cycles per legal command.
REQ-018 Minimum latency SHALL be: accept at edge N; NONSEQ in cycle N+1; data phase in cycle N+2; cmd_ack in cycle N+3. Each wait state SHALL add one cycle.
REQ-019 The block SHALL issue no BUSY, SEQ or burst transfers.

Reset
REQ-020 While rst=1, asynchronously: state=IDLE, htrans=0, haddr=0, hwrite=0, hsize=0, hwdata=0, cmd_busy=0, cmd_ack=0, cmd_err=0, cmd_rdata=0.
REQ-021 A reset asserted mid-transfer SHALL abandon the transfer with no cmd_ack; the first command after reset release SHALL behave as from power-up.

Verification
REQ-022 Read with defaults, hready=1 always: cmd_addr=0x100, size=2, hrdata=0xCAFEF00D -> NONSEQ haddr=0x100 at N+1; cmd_ack at N+3 with rdata=0xCAFEF00D, err=0.
REQ-023 Write with 2 wait states in the data phase: addr=0x204, wdata=0x12345678 -> hwdata=0x12345678 for 3 cycles; cmd_ack at N+5; err=0.
REQ-024 Two-cycle ERROR response: hresp=2'b01 with hready=0, then hresp=2'b01 with hready=1 -> cmd_ack with err=1.
REQ-025 Illegal commands: size=2 with addr=0x102, and size=3 -> htrans stays 0; cmd_ack at N+1 with err=1.
REQ-026 Mask/base: P_ADDR_MASK=0x0000FFFF, P_ADDR_BASE=0x40000000, addr=0x1234ABCC -> haddr=0x4000ABCC; 1 address-phase wait holds haddr for 2 cycles.
REQ-027 Back-to-back and reset: second cmd_req held during cmd_ack -> accepted immediately; rst asserted in DATA -> all outputs 0 at once and no cmd_ack.
